// File: rtl/hfosc_wake_ctrl.sv
// hfosc_wake_ctrl: sequences SB_HFOSC power-up/enable around sleep requests and wake events on the always-on slow clock
module hfosc_wake_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 2,
    parameter int N_WAKE        = 4
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              sleep_req,
    input  logic [N_WAKE-1:0] wake_evt,
    output logic              clkhf_powerup,
    output logic              clkhf_enable,
    output logic              clk_ready,
    output logic              sleep_ack,
    output logic [N_WAKE-1:0] wake_src
);
    typedef enum logic [1:0] {POWERUP, RUN, DRAIN, OFF} state_t;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              sleep_pend_q, sleep_pend_d;
    logic              sreq_q, sreq_d;
    logic [N_WAKE-1:0] wake_src_q, wake_src_d;
    logic              powerup_q, powerup_d;
    logic              enable_q, enable_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              sleep_edge, wake_any;

    assign sleep_edge = sleep_req & ~sreq_q;
    assign wake_any   = |wake_evt;
    assign sreq_d     = sleep_req;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q      <= POWERUP;
            cnt_q        <= '0;
            sleep_pend_q <= 1'b0;
            sreq_q       <= 1'b1;
            wake_src_q   <= '0;
            powerup_q    <= 1'b1;
            enable_q     <= 1'b0;
            ready_q      <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sleep_pend_q <= sleep_pend_d;
            sreq_q       <= sreq_d;
            wake_src_q   <= wake_src_d;
            powerup_q    <= powerup_d;
            enable_q     <= enable_d;
            ready_q      <= ready_d;
            ack_q        <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sleep_pend_d = sleep_pend_q;
        wake_src_d   = wake_src_q;
        case (state_q)
            POWERUP: begin
                sleep_pend_d = sleep_pend_q | sleep_edge;
                cnt_d        = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? '0 : cnt_q + 8'd1;
                state_d      = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? RUN : POWERUP;
            end
            RUN: begin
                // A wake event present alongside a sleep request cancels the request outright
                if (sleep_edge | sleep_pend_q) begin
                    sleep_pend_d = 1'b0;
                    state_d      = wake_any ? RUN : DRAIN;
                end
            end
            DRAIN: begin
                if (wake_any) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = (cnt_q == 8'(DRAIN_CYCLES - 1)) ? '0 : cnt_q + 8'd1;
                    state_d = (cnt_q == 8'(DRAIN_CYCLES - 1)) ? OFF : DRAIN;
                end
            end
            default: begin
                if (wake_any) begin
                    wake_src_d = wake_evt;
                    state_d    = POWERUP;
                    cnt_d      = '0;
                end
            end
        endcase
    end

    always_comb begin
        powerup_d = state_d != OFF;
        enable_d  = state_d == RUN;
        ready_d   = state_d == RUN;
        ack_d     = state_d == OFF;
    end

    assign clkhf_powerup = powerup_q;
    assign clkhf_enable  = enable_q;
    assign clk_ready     = ready_q;
    assign sleep_ack     = ack_q;
    assign wake_src      = wake_src_q;
endmodule
